// File: rtl/rs_scheduler_pkg.sv
// rtl/rs_scheduler_pkg.sv - shared widths, entry struct and wakeup helper for rs_scheduler
package rs_scheduler_pkg;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 8;
  localparam int BYTE_W = 8;
  localparam int ROB_W  = 4;
  localparam int NSRC   = 2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              rdy;
    logic [DATA_W-1:0] val;
  } src_t;

  typedef struct packed {
    logic              valid;
    logic [BYTE_W-1:0] operand;
    src_t [NSRC-1:0]   src;
    logic [BYTE_W-1:0] wbs;
    logic [BYTE_W-1:0] flags;
    logic [ROB_W-1:0]  robid;
  } entry_t;

  function automatic logic src_wakes(src_t s, logic cdb_valid, logic [TAG_W-1:0] cdb_id);
    return cdb_valid && !s.rdy && (s.tag == cdb_id);
  endfunction
endpackage

// File: rtl/rs_scheduler_if.sv
// rtl/rs_scheduler_if.sv - dispatch, CDB snoop, flush and FU issue bundle for rs_scheduler
interface rs_scheduler_if
  import rs_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                           disp_valid;
  logic                           disp_ready;
  logic [BYTE_W-1:0]              disp_operand;
  logic [NSRC-1:0][TAG_W-1:0]     disp_src_tag;
  logic [NSRC-1:0]                disp_src_rdy;
  logic [NSRC-1:0][DATA_W-1:0]    disp_src_val;
  logic [BYTE_W-1:0]              disp_wbs;
  logic [BYTE_W-1:0]              disp_flags;
  logic [ROB_W-1:0]               disp_robid;
  logic                           cdb_valid;
  logic [TAG_W-1:0]               cdb_id;
  logic [DATA_W-1:0]              cdb_val;
  logic                           flush;
  logic                           fu_hold;
  logic                           fu_transmit;
  logic [BYTE_W-1:0]              fu_operand;
  logic [NSRC-1:0][DATA_W-1:0]    fu_depvals;
  logic [BYTE_W-1:0]              fu_wbs;
  logic [BYTE_W-1:0]              fu_flags;
  logic [ROB_W-1:0]               fu_robid;
  logic [CNT_W-1:0]               occupancy;

  modport master (
    output disp_valid, disp_operand, disp_src_tag, disp_src_rdy, disp_src_val,
           disp_wbs, disp_flags, disp_robid, cdb_valid, cdb_id, cdb_val, flush, fu_hold,
    input  disp_ready, fu_transmit, fu_operand, fu_depvals, fu_wbs, fu_flags, fu_robid,
           occupancy
  );

  modport slave (
    input  disp_valid, disp_operand, disp_src_tag, disp_src_rdy, disp_src_val,
           disp_wbs, disp_flags, disp_robid, cdb_valid, cdb_id, cdb_val, flush, fu_hold,
    output disp_ready, fu_transmit, fu_operand, fu_depvals, fu_wbs, fu_flags, fu_robid,
           occupancy
  );
endinterface

// File: rtl/rs_entry_wakeup.sv
// rtl/rs_entry_wakeup.sv - one source operand: CDB tag compare and value capture
module rs_entry_wakeup
  import rs_scheduler_pkg::*;
(
  input  src_t              i_src,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_id,
  input  logic [DATA_W-1:0] i_cdb_val,
  output src_t              o_src
);
  logic w_hit;

  assign w_hit = src_wakes(i_src, i_cdb_valid, i_cdb_id);

  always_comb begin
    o_src = i_src;
    if (w_hit) begin
      o_src.rdy = 1'b1;
      o_src.val = i_cdb_val;
    end
  end
endmodule

// File: rtl/rs_scheduler.sv
// rtl/rs_scheduler.sv - collapsing-queue reservation station, oldest-ready-first issue
module rs_scheduler
  import rs_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input logic          clk,
  input logic          rst,
  rs_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t            r_ent [DEPTH];
  logic [CNT_W-1:0]  r_count;

  src_t              w_wsrc [DEPTH][NSRC];
  src_t              w_dsrc_in [NSRC];
  src_t              w_dsrc [NSRC];
  entry_t            w_woken [DEPTH+1];
  entry_t            w_next [DEPTH];
  entry_t            w_new;
  logic [DEPTH-1:0]  w_issuable;
  logic              w_any;
  logic [SEL_W-1:0]  w_sel;
  logic              w_issue;
  logic              w_accept;
  logic [CNT_W-1:0]  w_wr_idx;

  genvar g, s;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      for (s = 0; s < NSRC; s++) begin : g_src
        rs_entry_wakeup u_wake (
          .i_src      (r_ent[g].src[s]),
          .i_cdb_valid(bus.cdb_valid),
          .i_cdb_id   (bus.cdb_id),
          .i_cdb_val  (bus.cdb_val),
          .o_src      (w_wsrc[g][s])
        );
      end
      assign w_issuable[g] = r_ent[g].valid & r_ent[g].src[0].rdy & r_ent[g].src[1].rdy;
    end
    // the incoming entry snoops the same CDB so a same-cycle broadcast is not lost
    for (s = 0; s < NSRC; s++) begin : g_disp
      assign w_dsrc_in[s] = '{tag: bus.disp_src_tag[s], rdy: bus.disp_src_rdy[s],
                              val: bus.disp_src_val[s]};
      rs_entry_wakeup u_wake (
        .i_src      (w_dsrc_in[s]),
        .i_cdb_valid(bus.cdb_valid),
        .i_cdb_id   (bus.cdb_id),
        .i_cdb_val  (bus.cdb_val),
        .o_src      (w_dsrc[s])
      );
    end
  endgenerate

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_issuable[i]) begin
        w_any = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
  end

  assign w_issue         = ~rst & ~bus.flush & ~bus.fu_hold & w_any;
  assign bus.disp_ready  = (r_count < CNT_W'(DEPTH));
  assign w_accept        = bus.disp_valid & bus.disp_ready & ~bus.flush;
  assign w_wr_idx        = r_count - CNT_W'(w_issue);
  assign bus.fu_transmit = w_issue;
  assign bus.occupancy   = r_count;

  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.operand = bus.disp_operand;
    w_new.wbs     = bus.disp_wbs;
    w_new.flags   = bus.disp_flags;
    w_new.robid   = bus.disp_robid;
    for (int k = 0; k < NSRC; k++) w_new.src[k] = w_dsrc[k];
  end

  // the extra top slot is an empty entry shifted in when the last entry moves down
  always_comb begin
    w_woken[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_woken[i] = r_ent[i];
      for (int k = 0; k < NSRC; k++) w_woken[i].src[k] = w_wsrc[i][k];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_next[i] = (w_issue && i >= int'(w_sel)) ? w_woken[i+1] : w_woken[i];
      if (w_accept && i == int'(w_wr_idx)) w_next[i] = w_new;
      if (bus.flush) w_next[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      r_count <= bus.flush ? '0 : r_count + CNT_W'(w_accept) - CNT_W'(w_issue);
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_next[i];
    end
  end

  always_comb begin
    bus.fu_operand = '0;
    bus.fu_depvals = '0;
    bus.fu_wbs     = '0;
    bus.fu_flags   = '0;
    bus.fu_robid   = '0;
    if (w_issue) begin
      bus.fu_operand = r_ent[w_sel].operand;
      bus.fu_wbs     = r_ent[w_sel].wbs;
      bus.fu_flags   = r_ent[w_sel].flags;
      bus.fu_robid   = r_ent[w_sel].robid;
      for (int k = 0; k < NSRC; k++) bus.fu_depvals[k] = r_ent[w_sel].src[k].val;
    end
  end
endmodule

// File: tb/tb_rs_scheduler.sv
// tb/tb_rs_scheduler.sv - randomized and directed checks of rs_scheduler against a queue model
module tb_rs_scheduler;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]      op;
    logic [1:0][3:0] tag;
    logic [1:0]      rdy;
    logic [1:0][7:0] val;
    logic [7:0]      wbs;
    logic [7:0]      flags;
    logic [3:0]      robid;
  } m_ent_t;

  typedef struct packed {
    logic       r;
    logic       dv;
    m_ent_t     d;
    logic       cv;
    logic [3:0] cid;
    logic [7:0] cval;
    logic       fl;
    logic       hold;
  } stim_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_tests = 0;
  int     n_fail = 0;
  m_ent_t q[$];

  rs_scheduler_if #(.DEPTH(DEPTH)) bus ();

  rs_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic m_ent_t mk(input logic [7:0] op, input logic [3:0] t0, input logic r0,
                                input logic [7:0] v0, input logic [3:0] t1, input logic r1,
                                input logic [7:0] v1);
    m_ent_t e;
    e.op = op;
    e.tag[0] = t0; e.rdy[0] = r0; e.val[0] = v0;
    e.tag[1] = t1; e.rdy[1] = r1; e.val[1] = v1;
    e.wbs = op ^ 8'hA5;
    e.flags = op + 8'h11;
    e.robid = op[3:0];
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t disp(input m_ent_t e);
    stim_t s;
    s = '0;
    s.dv = 1'b1;
    s.d = e;
    return s;
  endfunction

  // one clock: drive, compare against the model's view, advance the model
  task automatic step(input stim_t s);
    int     sel;
    bit     tx, acc;
    m_ent_t e, n;
    rst              = s.r;
    bus.disp_valid   = s.dv;
    bus.disp_operand = s.d.op;
    bus.disp_src_tag = s.d.tag;
    bus.disp_src_rdy = s.d.rdy;
    bus.disp_src_val = s.d.val;
    bus.disp_wbs     = s.d.wbs;
    bus.disp_flags   = s.d.flags;
    bus.disp_robid   = s.d.robid;
    bus.cdb_valid    = s.cv;
    bus.cdb_id       = s.cid;
    bus.cdb_val      = s.cval;
    bus.flush        = s.fl;
    bus.fu_hold      = s.hold;
    #3;
    sel = -1;
    for (int k = 0; k < q.size(); k++)
      if (sel < 0 && q[k].rdy == 2'b11) sel = k;
    tx = !s.r && !s.fl && !s.hold && (sel >= 0);
    e = tx ? q[sel] : '0;
    check("occupancy",   32'(bus.occupancy),   32'(q.size()));
    check("disp_ready",  32'(bus.disp_ready),  32'(q.size() < DEPTH));
    check("fu_transmit", 32'(bus.fu_transmit), 32'(tx));
    check("fu_operand",  32'(bus.fu_operand),  32'(e.op));
    check("fu_depvals",  32'(bus.fu_depvals),  32'(e.val));
    check("fu_wbs",      32'(bus.fu_wbs),      32'(e.wbs));
    check("fu_flags",    32'(bus.fu_flags),    32'(e.flags));
    check("fu_robid",    32'(bus.fu_robid),    32'(e.robid));
    if (s.r || s.fl) begin
      q.delete();
    end else begin
      acc = s.dv && (q.size() < DEPTH);
      for (int k = 0; k < q.size(); k++)
        for (int j = 0; j < 2; j++)
          if (s.cv && !q[k].rdy[j] && q[k].tag[j] == s.cid) begin
            q[k].rdy[j] = 1'b1;
            q[k].val[j] = s.cval;
          end
      if (tx) q.delete(sel);
      if (acc) begin
        n = s.d;
        for (int j = 0; j < 2; j++)
          if (s.cv && !n.rdy[j] && n.tag[j] == s.cid) begin
            n.rdy[j] = 1'b1;
            n.val[j] = s.cval;
          end
        q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.r    = ($urandom_range(0, 199) == 0);
    s.dv   = ($urandom_range(0, 9) < 6);
    s.d    = mk(8'($urandom), 4'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
                8'($urandom), 4'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
                8'($urandom));
    s.d.wbs   = 8'($urandom);
    s.d.flags = 8'($urandom);
    s.d.robid = 4'($urandom);
    s.cv   = ($urandom_range(0, 1) == 1);
    s.cid  = 4'($urandom_range(0, 7));
    s.cval = 8'($urandom);
    s.fl   = ($urandom_range(0, 29) == 0);
    s.hold = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    bus.disp_valid = 1'b0; bus.disp_operand = '0; bus.disp_src_tag = '0;
    bus.disp_src_rdy = '0; bus.disp_src_val = '0; bus.disp_wbs = '0;
    bus.disp_flags = '0; bus.disp_robid = '0; bus.cdb_valid = 1'b0;
    bus.cdb_id = '0; bus.cdb_val = '0; bus.flush = 1'b0; bus.fu_hold = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    check("rst_occupancy",   32'(bus.occupancy),   32'd0);
    check("rst_disp_ready",  32'(bus.disp_ready),  32'd1);
    check("rst_fu_transmit", 32'(bus.fu_transmit), 32'd0);
    check("rst_fu_operand",  32'(bus.fu_operand),  32'd0);
    @(posedge clk);
    #1;

    // both sources ready: issue next cycle, then empty
    step(disp(mk(8'h21, 4'd1, 1'b1, 8'h10, 4'd2, 1'b1, 8'h20)));
    step(idle());
    step(idle());

    // wakeup two cycles after dispatch, issue one cycle after the CDB
    step(disp(mk(8'h35, 4'd3, 1'b0, 8'h00, 4'd4, 1'b1, 8'h44)));
    step(idle());
    s = idle(); s.cv = 1'b1; s.cid = 4'd3; s.cval = 8'h5A;
    step(s);
    step(idle());
    step(idle());

    // dispatch-time CDB bypass
    s = disp(mk(8'h36, 4'd5, 1'b0, 8'h00, 4'd6, 1'b1, 8'h66));
    s.cv = 1'b1; s.cid = 4'd5; s.cval = 8'h77;
    step(s);
    step(idle());

    // fill to DEPTH with entries 0 and 2 ready; ordering survives the collapse
    s = disp(mk(8'h40, 4'd0, 1'b1, 8'h01, 4'd0, 1'b1, 8'h02)); s.hold = 1'b1; step(s);
    s = disp(mk(8'h41, 4'd9, 1'b0, 8'h03, 4'd0, 1'b1, 8'h04)); s.hold = 1'b1; step(s);
    s = disp(mk(8'h42, 4'd0, 1'b1, 8'h05, 4'd0, 1'b1, 8'h06)); s.hold = 1'b1; step(s);
    s = disp(mk(8'h43, 4'd10, 1'b0, 8'h07, 4'd0, 1'b1, 8'h08)); s.hold = 1'b1; step(s);
    s = disp(mk(8'h44, 4'd0, 1'b1, 8'h09, 4'd0, 1'b1, 8'h0A)); s.hold = 1'b1; step(s);
    step(idle());
    step(idle());
    s = idle(); s.cv = 1'b1; s.cid = 4'd10; s.cval = 8'hC3; step(s);
    s = idle(); s.cv = 1'b1; s.cid = 4'd9;  s.cval = 8'hB2; step(s);
    step(idle());
    step(idle());

    // hold with ready entries, oldest goes first on release
    s = disp(mk(8'h50, 4'd0, 1'b1, 8'h11, 4'd0, 1'b1, 8'h12)); s.hold = 1'b1; step(s);
    s = disp(mk(8'h51, 4'd0, 1'b1, 8'h13, 4'd0, 1'b1, 8'h14)); s.hold = 1'b1; step(s);
    s = idle(); s.hold = 1'b1; step(s);
    step(idle());
    step(idle());

    // flush with three entries while a dispatch is offered
    for (int k = 0; k < 3; k++) begin
      s = disp(mk(8'(8'h60 + k), 4'd0, 1'b1, 8'h20, 4'd0, 1'b1, 8'h21));
      s.hold = 1'b1;
      step(s);
    end
    s = disp(mk(8'h6F, 4'd0, 1'b1, 8'h30, 4'd0, 1'b1, 8'h31)); s.fl = 1'b1; step(s);
    step(idle());

    for (int n = 0; n < 3000; n++) step(rand_stim());
    s = idle(); s.r = 1'b1; step(s);
    step(idle());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_scheduler.md
RS_SCHEDULER -- requirements
Module: rs_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, number of reservation-station entries (2..8).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 disp_valid  in  1  dispatch request.
REQ-005 disp_ready  out  1  entry available.
REQ-006 disp_operand  in  8  opcode/operand byte, carried unchanged to FU.
REQ-007 disp_src_tag  in  2x4  producer tag per source.
REQ-008 disp_src_rdy  in  2  source value already available.
REQ-009 disp_src_val  in  2x8  source value, valid where disp_src_rdy set.
REQ-010 disp_wbs / disp_flags  in  8 / 8  writeback selector and flags, carried unchanged.
REQ-011 disp_robid  in  4  ROB index, carried unchanged.
REQ-012 cdb_valid / cdb_id / cdb_val  in  1 / 4 / 8  broadcast result snoop.
REQ-013 flush  in  1  discard all entries (mispredict recovery).
REQ-014 fu_hold  in  1  FU cannot accept; driven from FU registered state only, with no combinational path from fu_transmit.
REQ-015 fu_transmit  out  1  issue strobe to FU.
REQ-016 fu_operand / fu_depvals / fu_wbs / fu_flags / fu_robid  out  8 / 2x8 / 8 / 8 / 4  issued entry fields.
REQ-017 occupancy  out  clog2(DEPTH+1)  number of valid entries.

Function
REQ-018 Entries are kept as a collapsing queue: index 0 holds the oldest entry, and valid entries are contiguous from index 0.
REQ-019 disp_ready = (occupancy < DEPTH), computed from registered state only; a same-cycle issue does not free a slot.
REQ-020 A dispatch is accepted when disp_valid & disp_ready & ~flush, and the new entry is written behind all entries surviving that cycle.
REQ-021 Wakeup: a valid entry source with rdy=0 and tag==cdb_id while cdb_valid captures cdb_val and sets rdy at the clock edge.
REQ-022 Dispatch bypass: an accepted source with disp_src_rdy=0 whose tag matches a same-cycle valid CDB is stored rdy=1 with cdb_val.
REQ-023 An entry is issuable when valid and both sources have rdy=1 in registered state; there is no same-cycle CDB-to-issue bypass, so wakeup-to-issue latency is 1 cycle minimum.
REQ-024 fu_transmit = ~fu_hold & ~flush & (any issuable entry); the selected entry is the lowest-index issuable entry (oldest first).
REQ-025 Issue output fields show the selected entry when fu_transmit=1, otherwise all zero.
REQ-026 An issued entry is removed at the edge; higher entries shift down one index, and wakeups apply to the shifted entries in the same edge.
REQ-027 Simultaneous issue and dispatch in one cycle: occupancy is unchanged and the new entry lands at index occupancy-1.
REQ-028 flush clears all valid bits at the edge, overrides dispatch and issue in that cycle, and forces fu_transmit=0.
REQ-029 At most one issue and one dispatch per cycle; occupancy never exceeds DEPTH or underflows.

Reset
REQ-030 On rst, all valid bits clear and occupancy=0; disp_ready=1 and fu_transmit=0 with zero issue fields in the cycle after.
REQ-031 rst mid-operation discards all entries without issuing; payload registers need not be reset.

Structure
REQ-032 The shared package holds the entry struct (valid, operand, 2x{tag,rdy,val}, wbs, flags, robid) and tag/data width constants (TAG_W=4, DATA_W=8).
REQ-033 One sub-module, rs_entry_wakeup, implements per-source tag compare and capture, instantiated 2 per entry.

Verification
REQ-034 Dispatch with both sources ready, fu_hold=0 -> fu_transmit=1 on the next cycle with matching fields; occupancy returns to 0.
REQ-035 Dispatch with src0 tag=3 not ready; CDB id=3 val=0x5A two cycles later -> issue one cycle after the CDB with fu_depvals[0]=0x5A.
REQ-036 Dispatch with src0 not ready while CDB id matches in the same cycle -> entry stored ready and issued the next cycle with the CDB value.
REQ-037 Fill 4 entries with entries 0 and 2 ready -> disp_ready=0; entry 0 issues first, then entry 2; order is preserved after the collapse.
REQ-038 Hold fu_hold=1 with ready entries for 3 cycles -> no issue; on release the oldest issues first.
REQ-039 Assert flush with 3 entries while dispatching -> occupancy=0, no fu_transmit, and the dispatched entry is not stored.
